axi_lite_master: RTL and testbench

- Single-outstanding AXI4-Lite initiator. Converts a simple command/response handshake into AXI4-Lite read and write transactions.
- Used by on-chip sequencers and debug logic to drive AXI4-Lite CSR slaves, including the accelerator's own CSR slave in loopback benches.
- Has one transaction in flight at a time, plus a watchdog that flags stalled slaves.

---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/axi_lite_if.sv | 43 ++++
 rtl/axi_lite_watchdog.sv | 41 ++++
 rtl/axi_lite_master.sv | 167 ++++++++++++++++
 tb/tb_axi_lite_master.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types and constants for the AXI4-Lite initiator
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } mst_state_e;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_watchdog.sv
// rtl/axi_lite_watchdog.sv - saturating stall counter with sticky timeout flag
module axi_lite_watchdog (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cnt_clr,
  input  logic        busy,
  input  logic        timeout_clr,
  input  logic [31:0] limit,
  output logic        timeout
);

  logic [31:0] cnt_q;
  logic        set_hit;

  // Widened compare so a saturated counter at the largest limit still reads as expired.
  assign set_hit = (limit != 32'd0) && busy &&
                   (({1'b0, cnt_q} + 33'd1) >= {1'b0, limit});

  // Count stalled cycles, holding at the limit instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else if (cnt_clr) begin
      cnt_q <= 32'd0;
    end else if (busy && (cnt_q < limit)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  // Sticky flag; a still-expired counter overrides a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if (set_hit) begin
      timeout <= 1'b1;
    end else if (timeout_clr) begin
      timeout <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite initiator with watchdog
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  output logic                    axi_timeout,
  input  logic                    timeout_clr,
  axi_lite_if.master              m_axi
);

  mst_state_e              state_q, state_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    alive_q;
  logic                    accept, cap_b, cap_r;
  logic                    wd_busy;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  axi_resp_e               resp_q;
  logic                    rsp_write_q;

  // alive_q keeps cmd_ready low while reset is held and for the first edge after it.
  assign cmd_ready = alive_q && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RSP);
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  // Every bus output comes from state or a register, never from cmd_* directly.
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = PROT_DEFAULT;
  assign m_axi.awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign m_axi.bready  = (state_q == WR_RESP);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = PROT_DEFAULT;
  assign m_axi.arvalid = (state_q == RD_REQ);
  assign m_axi.rready  = (state_q == RD_DATA);

  // Next-state and capture strobes; AW and W are tracked independently.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    accept    = 1'b0;
    cap_b     = 1'b0;
    cap_r     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept    = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | m_axi.awready;
        w_done_d  = w_done_q | m_axi.wready;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi.bvalid) begin
          cap_b   = 1'b1;
          state_d = RSP;
        end
      end
      RD_REQ: begin
        if (m_axi.arready) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi.rvalid) begin
          cap_r   = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and handshake bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      alive_q   <= 1'b1;
    end
  end

  // Command latch and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= OKAY;
      rsp_write_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
      end
      if (cap_b) begin
        rdata_q     <= '0;
        resp_q      <= axi_resp_e'(m_axi.bresp);
        rsp_write_q <= 1'b1;
      end else if (cap_r) begin
        rdata_q     <= m_axi.rdata;
        resp_q      <= axi_resp_e'(m_axi.rresp);
        rsp_write_q <= 1'b0;
      end
    end
  end

  // Waiting on the requester in RSP is not a slave stall.
  assign wd_busy = busy && (state_q != RSP);

  axi_lite_watchdog u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt_clr     (accept),
    .busy        (wd_busy),
    .timeout_clr (timeout_clr),
    .limit       (32'(TIMEOUT_CYCLES)),
    .timeout     (axi_timeout)
  );

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - directed self-checking bench for axi_lite_master
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy, axi_timeout, timeout_clr;

  int errors = 0;
  int checks = 0;
  int aw_cnt = 0;
  int w_cnt  = 0;
  int b_cyc  = 0;

  axi_lite_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  axi_lite_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .busy        (busy),
    .axi_timeout (axi_timeout),
    .timeout_clr (timeout_clr),
    .m_axi       (bus)
  );

  always #5 clk = ~clk;

  // Handshake tallies sampled on the active edge.
  always @(posedge clk) begin
    if (bus.awvalid && bus.awready) aw_cnt++;
    if (bus.wvalid && bus.wready) w_cnt++;
    if (bus.bready) b_cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zread(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; bus.arready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("rd_arvalid", bus.arvalid, 1);
    chk("rd_araddr", bus.araddr, a);
    bus.rvalid = 1'b1; bus.rdata = d; bus.rresp = r;
    chk("rd_stray_rready", bus.rready, 0);
    step();
    bus.arready = 1'b0;
    chk("rd_rready", bus.rready, 1);
    step();
    bus.rvalid = 1'b0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rdata", rsp_rdata, d);
    chk("rd_resp", rsp_resp, r);
    chk("rd_write", rsp_write, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_done_busy", busy, 0);
  endtask

  initial begin
    int a0, w0, b0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0; timeout_clr = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    step(); step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_timeout", axi_timeout, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_resp", rsp_resp, 0);
    chk("rst_awaddr", bus.awaddr, 0);
    chk("rst_prot", {bus.awprot, bus.arprot}, 0);
    rst_n = 1'b1;
    step();
    chk("idle_cmd_ready", cmd_ready, 1);

    // Zero-wait write
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cyc;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10;
    cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    bus.awready = 1'b1; bus.wready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("t1_awvalid", bus.awvalid, 1);
    chk("t1_wvalid", bus.wvalid, 1);
    chk("t1_awaddr", bus.awaddr, 8'h10);
    chk("t1_wdata", bus.wdata, 32'hDEADBEEF);
    chk("t1_wstrb", bus.wstrb, 4'hF);
    chk("t1_cmd_ready", cmd_ready, 0);
    chk("t1_busy", busy, 1);
    step();
    bus.awready = 1'b0; bus.wready = 1'b0;
    chk("t1_bready", bus.bready, 1);
    chk("t1_awvalid_drop", bus.awvalid, 0);
    chk("t1_wvalid_drop", bus.wvalid, 0);
    bus.bvalid = 1'b1; bus.bresp = OKAY;
    step();
    bus.bvalid = 1'b0;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_write", rsp_write, 1);
    chk("t1_rsp_resp", rsp_resp, 2'b00);
    chk("t1_rsp_rdata", rsp_rdata, 0);
    chk("t1_bready_drop", bus.bready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t1_rsp_done", rsp_valid, 0);
    chk("t1_idle_ready", cmd_ready, 1);
    chk("t1_aw_count", aw_cnt - a0, 1);
    chk("t1_w_count", w_cnt - w0, 1);
    chk("t1_bready_cycles", b_cyc - b0, 1);

    // Write with W delayed; SLVERR passes through
    a0 = aw_cnt; w0 = w_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h14;
    cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'h3;
    bus.awready = 1'b1; bus.wready = 1'b0;
    step();
    cmd_valid = 1'b0; cmd_wdata = 32'h0;
    for (int i = 1; i <= 6; i++) begin
      chk("t2_wvalid_held", bus.wvalid, 1);
      chk("t2_wdata_stable", bus.wdata, 32'h0BADF00D);
      chk("t2_awvalid", bus.awvalid, (i == 1));
      if (i == 6) bus.wready = 1'b1;
      step();
    end
    bus.wready = 1'b0; bus.awready = 1'b0;
    chk("t2_bready", bus.bready, 1);
    bus.bvalid = 1'b1; bus.bresp = SLVERR;
    step();
    bus.bvalid = 1'b0;
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_resp", rsp_resp, 2'b10);
    chk("t2_rsp_write", rsp_write, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t2_aw_count", aw_cnt - a0, 1);
    chk("t2_w_count", w_cnt - w0, 1);

    // Read with AR delayed 3 and R delayed 2
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h04;
    step();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("t3_arvalid", bus.arvalid, 1);
      chk("t3_araddr", bus.araddr, 8'h04);
      chk("t3_cmd_ready", cmd_ready, 0);
      if (i == 4) bus.arready = 1'b1;
      step();
    end
    bus.arready = 1'b0;
    chk("t3_arvalid_drop", bus.arvalid, 0);
    for (int i = 5; i <= 7; i++) begin
      chk("t3_rready", bus.rready, 1);
      chk("t3_cmd_ready_wait", cmd_ready, 0);
      if (i == 7) begin
        bus.rvalid = 1'b1; bus.rdata = 32'h12345678; bus.rresp = OKAY;
      end
      step();
    end
    bus.rvalid = 1'b0;
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("t3_rsp_write", rsp_write, 0);
    step();
    chk("t3_rsp_hold", rsp_valid, 1);
    chk("t3_cmd_ready_rsp", cmd_ready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t3_idle_ready", cmd_ready, 1);

    // DECERR read with a stalled consumer and a queued command
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h0C; bus.arready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("t4_arvalid", bus.arvalid, 1);
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'hCAFEF00D; bus.rresp = DECERR;
    chk("t4_rready", bus.rready, 1);
    step();
    bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = OKAY;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08;
    for (int i = 0; i < 10; i++) begin
      chk("t4_rsp_valid", rsp_valid, 1);
      chk("t4_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("t4_rsp_resp", rsp_resp, 2'b11);
      chk("t4_rsp_write", rsp_write, 0);
      chk("t4_cmd_blocked", cmd_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    chk("t4_cmd_blocked_hs", cmd_ready, 0);
    step();
    rsp_ready = 1'b0;
    chk("t4_rsp_cleared", rsp_valid, 0);
    chk("t4_next_ready", cmd_ready, 1);
    zread(8'h08, 32'h00005A5A, OKAY);

    // Watchdog with AW never accepted
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h18;
    cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    bus.awready = 1'b0; bus.wready = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) bus.wready = 1'b0;
      chk("t5_timeout", axi_timeout, (k == 16));
      chk("t5_awvalid", bus.awvalid, 1);
    end
    chk("t5_wvalid_done", bus.wvalid, 0);
    timeout_clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_clr_blocked", axi_timeout, 1);
      chk("t5_awvalid_clr", bus.awvalid, 1);
    end
    timeout_clr = 1'b0; bus.awready = 1'b1;
    step();
    bus.awready = 1'b0;
    chk("t5_bready", bus.bready, 1);
    bus.bvalid = 1'b1; bus.bresp = OKAY;
    step();
    bus.bvalid = 1'b0;
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_timeout_kept", axi_timeout, 1);
    timeout_clr = 1'b1; rsp_ready = 1'b1;
    step();
    timeout_clr = 1'b0; rsp_ready = 1'b0;
    chk("t5_timeout_cleared", axi_timeout, 0);
    chk("t5_busy", busy, 0);

    // Reset while waiting for B
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h1C;
    cmd_wdata = 32'h77; cmd_wstrb = 4'hF;
    bus.awready = 1'b1; bus.wready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    bus.awready = 1'b0; bus.wready = 1'b0;
    chk("t6_in_wr_resp", bus.bready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_bready", bus.bready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_awvalid", bus.awvalid, 0);
    chk("t6_wvalid", bus.wvalid, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_cmd_ready", cmd_ready, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_no_completion", rsp_valid, 0);
    chk("t6_ready_again", cmd_ready, 1);
    zread(8'h20, 32'hA5A50001, OKAY);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
